mem_stage_p: RTL and testbench

Parametrised memory-access pipeline stage between execute and write-back. Accepts one EX bundle per valid/ready handshake, passes ALU results through in one cycle, issues loads and stores to a variable-latency memory port through a req/gnt/rvalid handshake, and supports byte, half and full-width accesses with sign/zero extension. Replaces the fixed-width, cache-coupled stage that used a single `delay` stall line, which had no backpressure and no sub-word access.

---
 rtl/mem_stage_p.sv | 164 ++++++++++++++++
 tb/tb_mem_stage_p.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_p.sv
// Memory-access stage between execute and write-back.
// ALU results pass in one cycle; loads/stores use a req/gnt/rvalid port.
module mem_stage_p #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 16,
  parameter int DEST_W = 5,
  parameter int OP_W = 4,
  parameter logic [OP_W-1:0] OP_LOAD = 4'b1000,
  parameter logic [OP_W-1:0] OP_STORE = 4'b1001
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   in_op,
  input  logic [DEST_W-1:0] in_dest,
  input  logic [DATA_W-1:0] in_answer,
  input  logic [DATA_W-1:0] in_value,
  input  logic [1:0]        in_size,
  input  logic              in_signed,
  output logic [DEST_W-1:0] fwd_dest,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W/8-1:0] mem_be,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OP_W-1:0]   out_op,
  output logic [DEST_W-1:0] out_dest,
  output logic [DATA_W-1:0] out_answer,
  output logic [DATA_W-1:0] out_mem,
  output logic              out_err
);

  localparam int BE_W = DATA_W / 8;
  localparam int LSB = $clog2(BE_W);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [DEST_W-1:0] dest;
    logic [DATA_W-1:0] answer;
    logic [DATA_W-1:0] value;
    logic [1:0]        size;
    logic              sgn;
  } memOp_t;

  state_t state, stateNext;
  memOp_t pend;

  logic accept, inMem, inMis;
  logic aluDone, storeDone, loadDone;
  logic [LSB-1:0] off;
  logic [DATA_W-1:0] lane, loadData;

  assign fwd_dest = in_valid ? in_dest : '0;
  assign inMem = (in_op == OP_LOAD) || (in_op == OP_STORE);
  assign accept = in_valid && in_ready;
  assign off = pend.answer[LSB-1:0];

  always_comb begin
    inMis = 1'b0;
    unique case (1'b1)
      in_size == 2'b00: inMis = 1'b0;
      in_size == 2'b01: inMis = in_answer[0];
      default: inMis = |in_answer[LSB-1:0];
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    unique case (state)
      IDLE: if (accept && inMem && !inMis) stateNext = REQ;
      REQ: if (mem_gnt) stateNext = mem_we ? IDLE : WAIT;
      WAIT: if (mem_rvalid) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_comb begin
    mem_req = (state == REQ);
    in_ready = (state == IDLE) && (!out_valid || out_ready);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) pend <= '0;
    else if (accept && inMem)
      pend <= '{in_op, in_dest, in_answer, in_value, in_size, in_signed};
  end

  assign mem_we = (pend.op == OP_STORE);
  assign mem_addr = pend.answer[ADDR_W+LSB-1:LSB];

  // Sub-word stores replicate the data so any lane can pick it up.
  always_comb begin
    mem_wdata = pend.value;
    mem_be = '1;
    unique case (1'b1)
      pend.size == 2'b00: begin
        mem_wdata = {BE_W{pend.value[7:0]}};
        mem_be = BE_W'(1) << off;
      end
      pend.size == 2'b01: begin
        mem_wdata = {(BE_W/2){pend.value[15:0]}};
        mem_be = BE_W'(3) << off;
      end
      default: ;
    endcase
  end

  always_comb begin
    lane = mem_rdata >> {off, 3'b000};
    loadData = lane;
    unique case (1'b1)
      pend.size == 2'b00:
        loadData = {{(DATA_W-8){pend.sgn & lane[7]}}, lane[7:0]};
      pend.size == 2'b01:
        loadData = {{(DATA_W-16){pend.sgn & lane[15]}}, lane[15:0]};
      default: ;
    endcase
  end

  assign aluDone = accept && (!inMem || inMis);
  assign storeDone = (state == REQ) && mem_gnt && mem_we;
  assign loadDone = (state == WAIT) && mem_rvalid;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid <= 1'b0;
      out_op <= '0;
      out_dest <= '0;
      out_answer <= '0;
      out_mem <= '0;
      out_err <= 1'b0;
    end else if (aluDone) begin
      out_valid <= 1'b1;
      out_op <= in_op;
      out_dest <= in_dest;
      out_answer <= in_answer;
      out_mem <= '0;
      out_err <= inMem;
    end else if (storeDone || loadDone) begin
      out_valid <= 1'b1;
      out_op <= pend.op;
      out_dest <= pend.dest;
      out_answer <= pend.answer;
      out_mem <= loadDone ? loadData : '0;
      out_err <= 1'b0;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_stage_p.sv
// Scoreboard bench for mem_stage_p: random traffic against an arithmetic
// reference model plus directed latency, backpressure and reset cases.
module tb_mem_stage_p;

  localparam int NEVER = 1000;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [3:0] in_op = '0;
  logic [4:0] in_dest = '0;
  logic [31:0] in_answer = '0;
  logic [31:0] in_value = '0;
  logic [1:0] in_size = '0;
  logic in_signed = 1'b0;
  logic [4:0] fwd_dest;
  logic mem_req, mem_we;
  logic [15:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0] mem_be;
  logic mem_gnt = 1'b0;
  logic mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic out_valid;
  logic out_ready = 1'b1;
  logic [3:0] out_op;
  logic [4:0] out_dest;
  logic [31:0] out_answer, out_mem;
  logic out_err;

  mem_stage_p dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_dest(in_dest), .in_answer(in_answer),
    .in_value(in_value), .in_size(in_size), .in_signed(in_signed),
    .fwd_dest(fwd_dest),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_op(out_op),
    .out_dest(out_dest), .out_answer(out_answer), .out_mem(out_mem),
    .out_err(out_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] op;
    logic [4:0] dest;
    logic [31:0] answer;
    logic [31:0] mem;
    logic err;
  } exp_t;

  typedef struct {
    logic we;
    logic [15:0] addr;
    logic [3:0] be;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int gntDly;
    int rvDly;
  } req_t;

  int checks = 0;
  int errors = 0;
  longint cyc = 0;
  longint gntCyc = 0;
  longint acceptCyc = 0;
  int lastWait = 0;
  int phase = 0;
  logic randReady = 1'b0;
  logic forcedReady = 1'b1;
  logic stray = 1'b0;
  exp_t sbQ[$];
  req_t reqQ[$];
  longint popCyc[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    out_ready = randReady ? (($urandom % 4) != 0) : forcedReady;
  end

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  // Reference: byte-level arithmetic over the little-endian word.
  function automatic void model(
    input logic [3:0] op, input logic [4:0] dest,
    input logic [31:0] answer, input logic [31:0] value,
    input logic [1:0] size, input logic sgn, input logic [31:0] rdata,
    output exp_t e, output logic isReq, output req_t r);
    int sz, off;
    longint v;
    sz = (size == 0) ? 1 : (size == 1) ? 2 : 4;
    off = int'(answer % 4);
    e.op = op; e.dest = dest; e.answer = answer;
    e.mem = '0; e.err = 1'b0;
    isReq = 1'b0;
    r.we = 1'b0; r.addr = '0; r.be = '0; r.wdata = '0; r.rdata = rdata;
    r.gntDly = 0; r.rvDly = 0;
    if (op == 4'd8 || op == 4'd9) begin
      if ((answer % sz) != 0) e.err = 1'b1;
      else begin
        isReq = 1'b1;
        r.we = (op == 4'd9);
        r.addr = 16'((answer / 4) % 65536);
        r.be = 4'(((1 << sz) - 1) << off);
        for (int i = 0; i < 4; i++)
          r.wdata[8*i +: 8] = value[8*(i % sz) +: 8];
        if (op == 4'd8) begin
          v = (longint'(rdata) >> (8 * off)) % (longint'(1) << (8 * sz));
          if (sgn && sz < 4 && v >= (longint'(1) << (8 * sz - 1)))
            v -= longint'(1) << (8 * sz);
          e.mem = 32'(v);
        end
      end
    end
  endfunction

  task automatic send(input logic [3:0] op, input logic [4:0] dest,
                      input logic [31:0] answer, input logic [31:0] value,
                      input logic [1:0] size, input logic sgn,
                      input logic [31:0] rdata, input int gntDly,
                      input int rvDly);
    exp_t e;
    req_t r;
    logic isReq, hs, ok;
    int w;
    model(op, dest, answer, value, size, sgn, rdata, e, isReq, r);
    r.gntDly = gntDly;
    r.rvDly = rvDly;
    @(negedge clk);
    in_valid = 1'b1; in_op = op; in_dest = dest; in_answer = answer;
    in_value = value; in_size = size; in_signed = sgn;
    #1 chk("fwd_dest", 64'(fwd_dest), 64'(dest));
    w = 0;
    ok = 1'b1;
    forever begin
      hs = in_ready;
      @(posedge clk);
      if (hs) break;
      w++;
      if (w > 200) begin
        checks++; errors++; ok = 1'b0;
        $display("FAIL accept_timeout got none want handshake");
        break;
      end
      @(negedge clk);
    end
    if (ok) begin
      lastWait = w;
      sbQ.push_back(e);
      if (isReq) reqQ.push_back(r);
    end
    #1;
    in_valid = 1'b0;
    acceptCyc = cyc;
  endtask

  task automatic drain();
    int n = 0;
    while ((sbQ.size() != 0 || reqQ.size() != 0 || phase != 0) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) begin
      checks++; errors++;
      $display("FAIL drain_timeout got %0d pending want 0", sbQ.size());
    end
    @(negedge clk);
  endtask

  // Monitor: every accepted result is popped and compared.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (reset && out_valid && out_ready) begin
      if (sbQ.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_out got answer %0h want none", out_answer);
      end else begin
        e = sbQ.pop_front();
        chk("out_op", 64'(out_op), 64'(e.op));
        chk("out_dest", 64'(out_dest), 64'(e.dest));
        chk("out_answer", 64'(out_answer), 64'(e.answer));
        chk("out_mem", 64'(out_mem), 64'(e.mem));
        chk("out_err", 64'(out_err), 64'(e.err));
        popCyc.push_back(cyc);
      end
    end
  end

  // Memory responder driven by the expected-request queue.
  always @(negedge clk) begin : responder
    int cnt;
    req_t cur;
    mem_gnt = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata = $urandom;
    if (!reset) phase = 0;
    else begin
      if (phase == 0 && mem_req) begin
        if (reqQ.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_req got addr %0h want none", mem_addr);
          mem_gnt = 1'b1;
        end else begin
          cur = reqQ.pop_front();
          cnt = cur.gntDly;
          phase = 1;
        end
      end
      if (phase == 1) begin
        if (cnt == 0) begin
          chk("mem_req", 64'(mem_req), 64'd1);
          chk("mem_we", 64'(mem_we), 64'(cur.we));
          chk("mem_addr", 64'(mem_addr), 64'(cur.addr));
          if (cur.we) begin
            chk("mem_be", 64'(mem_be), 64'(cur.be));
            chk("mem_wdata", 64'(mem_wdata), 64'(cur.wdata));
          end
          mem_gnt = 1'b1;
          gntCyc = cyc;
          if (cur.we) phase = 0;
          else begin
            phase = 2;
            cnt = cur.rvDly;
          end
        end else cnt--;
      end else if (phase == 2) begin
        if (cnt == 0) begin
          mem_rvalid = 1'b1;
          mem_rdata = cur.rdata;
          phase = 0;
        end else if (cnt < NEVER) cnt--;
      end else if (phase == 0 && stray) begin
        mem_rvalid = 1'b1;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] op;
    logic [1:0] sz;
    logic [31:0] ans;
    int n;
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_mem_req", 64'(mem_req), 64'd0);
    chk("rst_out_err", 64'(out_err), 64'd0);
    chk("rst_out_answer", 64'(out_answer), 64'd0);
    chk("rst_out_mem", 64'(out_mem), 64'd0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1 chk("ready_after_reset", 64'(in_ready), 64'd1);

    popCyc.delete();
    send(4'd1, 5'd1, 32'h11111111, 32'h0, 2'd2, 1'b0, 32'h0, 0, 0);
    send(4'd2, 5'd2, 32'h22222222, 32'h0, 2'd2, 1'b0, 32'h0, 0, 0);
    send(4'd3, 5'd3, 32'h33333333, 32'h0, 2'd2, 1'b0, 32'h0, 0, 0);
    drain();
    chk("alu_count", 64'(popCyc.size()), 64'd3);
    if (popCyc.size() == 3) begin
      chk("alu_b2b_1", 64'(popCyc[1] - popCyc[0]), 64'd1);
      chk("alu_b2b_2", 64'(popCyc[2] - popCyc[1]), 64'd1);
    end

    popCyc.delete();
    send(4'd9, 5'd7, 32'h1003, 32'hA5, 2'd0, 1'b0, 32'h0, 2, 0);
    drain();
    if (popCyc.size() == 1)
      chk("store_latency", 64'(popCyc[0]), 64'(gntCyc + 1));
    else chk("store_count", 64'(popCyc.size()), 64'd1);

    send(4'd8, 5'd8, 32'h2002, 32'h0, 2'd1, 1'b1, 32'h80FF1234, 1, 2);
    drain();
    send(4'd8, 5'd9, 32'h2002, 32'h0, 2'd1, 1'b0, 32'h80FF1234, 0, 2);
    drain();

    popCyc.delete();
    send(4'd8, 5'd10, 32'h0006, 32'h0, 2'd2, 1'b0, 32'h0, 0, 0);
    drain();
    if (popCyc.size() == 1)
      chk("misalign_latency", 64'(popCyc[0]), 64'(acceptCyc));
    else chk("misalign_count", 64'(popCyc.size()), 64'd1);

    forcedReady = 1'b0;
    @(posedge clk);
    #2;
    send(4'd6, 5'd11, 32'hCAFE0006, 32'h0, 2'd2, 1'b0, 32'h0, 0, 0);
    repeat (4) begin
      @(negedge clk);
      chk("hold_in_ready", 64'(in_ready), 64'd0);
      chk("hold_out_valid", 64'(out_valid), 64'd1);
      chk("hold_answer", 64'(out_answer), 64'hCAFE0006);
    end
    forcedReady = 1'b1;
    @(posedge clk);
    #2;
    send(4'd7, 5'd12, 32'hBEEF0007, 32'h0, 2'd2, 1'b0, 32'h0, 0, 0);
    chk("release_accept_wait", 64'(lastWait), 64'd0);
    drain();

    send(4'd8, 5'd13, 32'h40, 32'h0, 2'd2, 1'b0, 32'h12345678, 0, NEVER);
    n = 0;
    while (phase != 2 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("reached_wait", 64'(phase), 64'd2);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("abort_out_valid", 64'(out_valid), 64'd0);
    chk("abort_mem_req", 64'(mem_req), 64'd0);
    sbQ.delete();
    reqQ.delete();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #2 stray = 1'b1;
    @(posedge clk);
    #2 stray = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("stray_out_valid", 64'(out_valid), 64'd0);
      chk("stray_in_ready", 64'(in_ready), 64'd1);
      chk("stray_mem_req", 64'(mem_req), 64'd0);
    end

    randReady = 1'b1;
    for (int i = 0; i < 300; i++) begin
      n = $urandom % 3;
      if (n == 0) begin
        op = 4'($urandom % 14);
        if (op >= 4'd8) op = op + 4'd2;
      end else op = (n == 1) ? 4'd8 : 4'd9;
      sz = 2'($urandom % 4);
      ans = $urandom;
      if (($urandom % 4) != 0)
        ans = ans & ((sz == 0) ? 32'hFFFFFFFF : (sz == 1) ? 32'hFFFFFFFE : 32'hFFFFFFFC);
      if (($urandom % 4) == 0) repeat ($urandom % 3) @(negedge clk);
      send(op, 5'($urandom), ans, $urandom, sz, 1'($urandom),
           $urandom, int'($urandom % 4), int'($urandom % 4));
    end
    randReady = 1'b0;
    forcedReady = 1'b1;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
